stack_lander: RTL and testbench

// - Consumer side of the block-shift row: accepts the block position frozen by the stop button.
// - Trims the stopped block against the row beneath it. Writes the surviving bits into the playfield.
// - Hands the trimmed block back as the start width for the next row.
// - Sits between the block shifter and the display/scoring logic; detects game over (total miss) and win (top row filled).

---
 rtl/stack_lander.sv | 137 +++++++++++++
 tb/tb_stack_lander.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stack_lander.sv
// Stack lander: trims a stopped block against the row beneath, writes it into the playfield, and flags miss/win.
// Optional STACK_SCORE_EN adds a saturating 16-bit score output.
module stack_lander #(
  parameter int              WIDTH      = 8,
  parameter int              ROWS       = 8,
  parameter logic [WIDTH-1:0] INIT_BLOCK = WIDTH'(8'b00011100),
  localparam int             LW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] blockLoc,
  input  logic             stopPulse,
  output logic             placeReady,
  output logic             placeDone,
  output logic [WIDTH-1:0] nextBlock,
  output logic [LW-1:0]    level,
  input  logic [LW-1:0]    rdRow,
  output logic [WIDTH-1:0] rdData,
  output logic             gameOver,
  output logic             gameWin
`ifdef STACK_SCORE_EN
  ,
  output logic [15:0]      score
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_OVER, S_WIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] overlap_q;
  logic [WIDTH-1:0] overlap_d;
  logic [WIDTH-1:0] prev_row_q;
  logic [WIDTH-1:0] next_block_q;
  logic [LW-1:0]    level_q;
  logic             place_done_q;
  logic             game_over_q;
  logic             game_win_q;
  logic [WIDTH-1:0] playfield_q [ROWS];

  assign overlap_d = cap_q & prev_row_q;

`ifdef STACK_SCORE_EN
  logic [15:0] score_q;
  logic [15:0] score_d;
  logic [15:0] ones_d;
  logic [16:0] score_sum_d;

  always_comb begin
    ones_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_d = ones_d + 16'(overlap_q[i]);
    end
    score_sum_d = {1'b0, score_q} + {1'b0, ones_d} + 17'(level_q);
    score_d     = score_sum_d[16] ? 16'hFFFF : score_sum_d[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
    end else if (state_q == S_WRITE) begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cap_q        <= '0;
      overlap_q    <= '0;
      prev_row_q   <= '1;
      next_block_q <= INIT_BLOCK;
      level_q      <= '0;
      place_done_q <= 1'b0;
      game_over_q  <= 1'b0;
      game_win_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        playfield_q[r] <= '0;
      end
    end else begin
      place_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (stopPulse) begin
            cap_q   <= blockLoc;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          overlap_q <= overlap_d;
          if (overlap_d == '0) begin
            game_over_q <= 1'b1;
            state_q     <= S_OVER;
          end else begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          playfield_q[level_q] <= overlap_q;
          prev_row_q           <= overlap_q;
          next_block_q         <= overlap_q;
          place_done_q         <= 1'b1;
          // Top row filled: level saturates rather than wrapping.
          if (level_q == LW'(ROWS - 1)) begin
            game_win_q <= 1'b1;
            state_q    <= S_WIN;
          end else begin
            level_q <= level_q + 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_OVER:  state_q <= S_OVER;
        S_WIN:   state_q <= S_WIN;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Addresses beyond the last row (non-power-of-2 ROWS) read as empty.
  always_comb begin
    rdData = '0;
    if (32'(rdRow) < ROWS) begin
      rdData = playfield_q[rdRow];
    end
  end

  assign placeReady = (state_q == S_IDLE);
  assign placeDone  = place_done_q;
  assign nextBlock  = next_block_q;
  assign level      = level_q;
  assign gameOver   = game_over_q;
  assign gameWin    = game_win_q;

endmodule

// File: tb/tb_stack_lander.sv
// Directed bench for stack_lander: landing, trimming, miss, win, ignored pulses and reset abort.
module tb_stack_lander;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] blockLoc;
  logic       stopPulse;
  logic       placeReady;
  logic       placeDone;
  logic [7:0] nextBlock;
  logic [2:0] level;
  logic [2:0] rdRow;
  logic [7:0] rdData;
  logic       gameOver;
  logic       gameWin;
`ifdef STACK_SCORE_EN
  logic [15:0] score;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  stack_lander dut (
    .clk       (clk),
    .rst       (rst),
    .blockLoc  (blockLoc),
    .stopPulse (stopPulse),
    .placeReady(placeReady),
    .placeDone (placeDone),
    .nextBlock (nextBlock),
    .level     (level),
    .rdRow     (rdRow),
    .rdData    (rdData),
    .gameOver  (gameOver),
    .gameWin   (gameWin)
`ifdef STACK_SCORE_EN
    ,
    .score     (score)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic read_row(input logic [2:0] row, input logic [7:0] exp, input string tag);
    rdRow = row;
    #1;
    check(tag, 32'(rdData), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stopPulse = 1'b0; blockLoc = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One accepted drop that lands; optionally fires a stray stopPulse while in S_CHECK.
  task automatic drop(input logic [7:0] blk, input logic [7:0] exp_next, input logic [2:0] exp_level,
                      input logic [2:0] row, input logic exp_ready, input logic stray);
    @(negedge clk);
    blockLoc = blk; stopPulse = 1'b1;
    @(negedge clk);
    check("busy_after_accept", 32'(placeReady), 32'd0);
    stopPulse = stray; blockLoc = stray ? 8'hFF : blk;
    @(negedge clk);
    stopPulse = 1'b0;
    check("done_low_in_write", 32'(placeDone), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(placeDone), 32'd1);
    check("next_block", 32'(nextBlock), 32'(exp_next));
    check("level", 32'(level), 32'(exp_level));
    check("ready_after_write", 32'(placeReady), 32'(exp_ready));
    read_row(row, exp_next, "row_written");
    @(negedge clk);
    check("done_cleared", 32'(placeDone), 32'd0);
  endtask

  initial begin
    rst = 1'b1; stopPulse = 1'b0; blockLoc = '0; rdRow = '0;
    do_reset();

    check("rst_ready", 32'(placeReady), 32'd1);
    check("rst_done", 32'(placeDone), 32'd0);
    check("rst_next", 32'(nextBlock), 32'h1C);
    check("rst_level", 32'(level), 32'd0);
    check("rst_over", 32'(gameOver), 32'd0);
    check("rst_win", 32'(gameWin), 32'd0);
    read_row(3'd0, 8'h00, "rst_row0");
    read_row(3'd7, 8'h00, "rst_row7");
`ifdef STACK_SCORE_EN
    check("rst_score", 32'(score), 32'd0);
`endif

    // Row 0 lands whole, row 1 trimmed to 00001100.
    drop(8'b00011100, 8'b00011100, 3'd1, 3'd0, 1'b1, 1'b0);
    drop(8'b00001110, 8'b00001100, 3'd2, 3'd1, 1'b1, 1'b0);

    // Total miss against 00001100.
    @(negedge clk);
    blockLoc = 8'b00110000; stopPulse = 1'b1;
    @(negedge clk);
    stopPulse = 1'b0;
    @(negedge clk);
    check("miss_over", 32'(gameOver), 32'd1);
    check("miss_ready", 32'(placeReady), 32'd0);
    blockLoc = 8'hFF; stopPulse = 1'b1;
    @(negedge clk);
    stopPulse = 1'b0;
    repeat (4) @(negedge clk);
    read_row(3'd2, 8'h00, "over_row2_frozen");
    check("over_level_held", 32'(level), 32'd2);
    check("over_sticky", 32'(gameOver), 32'd1);
    check("over_ready", 32'(placeReady), 32'd0);
    check("over_no_done", 32'(placeDone), 32'd0);

    // blockLoc == 0 is a miss even on row 0.
    do_reset();
    @(negedge clk);
    blockLoc = 8'h00; stopPulse = 1'b1;
    @(negedge clk);
    stopPulse = 1'b0;
    @(negedge clk);
    check("zero_over", 32'(gameOver), 32'd1);
    read_row(3'd0, 8'h00, "zero_row0");

    // Eight aligned drops reach the top; a stray pulse in S_CHECK on drop 3 must be ignored.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drop(8'b00011100, 8'b00011100, (i == 7) ? 3'd7 : 3'(i + 1), 3'(i),
           (i == 7) ? 1'b0 : 1'b1, (i == 2));
    end
    check("win_flag", 32'(gameWin), 32'd1);
    check("win_over", 32'(gameOver), 32'd0);
    check("win_level", 32'(level), 32'd7);
`ifdef STACK_SCORE_EN
    check("win_score", 32'(score), 32'd52);
`endif
    @(negedge clk);
    blockLoc = 8'h01; stopPulse = 1'b1;
    @(negedge clk);
    stopPulse = 1'b0;
    repeat (3) @(negedge clk);
    check("win_no_done", 32'(placeDone), 32'd0);
    read_row(3'd7, 8'b00011100, "win_row7_held");

    // Reset in S_WRITE together with stopPulse: reset values, no write.
    do_reset();
    @(negedge clk);
    blockLoc = 8'b00011100; stopPulse = 1'b1;
    @(negedge clk);
    stopPulse = 1'b0;
    @(negedge clk);
    rst = 1'b1; stopPulse = 1'b1; blockLoc = 8'hFF;
    @(negedge clk);
    check("abort_ready", 32'(placeReady), 32'd1);
    check("abort_done", 32'(placeDone), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    check("abort_next", 32'(nextBlock), 32'h1C);
    read_row(3'd0, 8'h00, "abort_row0");
    rst = 1'b0; stopPulse = 1'b0;
    @(negedge clk);
    check("abort_ready_after_release", 32'(placeReady), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
